// File: rtl/xrad_conv_engine.sv
// rtl/xrad_conv_engine.sv - multi-channel KSIZE x KSIZE convolution MAC with scale/saturate and result handshake
module xrad_conv_engine #(
  parameter int NCH    = 4,
  parameter int KSIZE  = 3,
  parameter int DATA_W = 16,
  parameter int COEF_W = 16,
  parameter int FRAC_W = 8,
  parameter int OUT_W  = 16,
  parameter int ACC_W  = DATA_W + COEF_W + $clog2(KSIZE * KSIZE * NCH) + 1
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              clr,
  input  logic                              mode,
  input  logic                              coef_we,
  input  logic [$clog2(KSIZE*KSIZE)-1:0]    coef_addr,
  input  logic [COEF_W-1:0]                 coef_wdata,
  output logic                              coef_err,
  input  logic                              tap_valid,
  output logic                              tap_ready,
  input  logic [NCH*DATA_W-1:0]             tap_data,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [NCH*OUT_W-1:0]              out_data,
  output logic [NCH-1:0]                    out_sat,
  output logic                              busy
);

  localparam int TAPS   = KSIZE * KSIZE;
  localparam int CNT_W  = $clog2(TAPS);
  localparam int PROD_W = DATA_W + COEF_W;

  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  typedef enum logic [1:0] {ACCUM, SCALE, OUT} state_t;

  state_t                     r_state;
  logic [CNT_W-1:0]           r_tap_cnt;
  logic signed [COEF_W-1:0]   r_coef [TAPS];
  logic signed [ACC_W-1:0]    r_acc  [NCH];
  logic                       r_tap_ready;
  logic                       r_out_valid;
  logic [NCH*OUT_W-1:0]       r_out_data;
  logic [NCH-1:0]             r_out_sat;
  logic                       r_coef_err;

  logic                       w_busy;
  logic                       w_last;
  logic                       w_addr_ok;
  logic signed [COEF_W-1:0]   w_coef;
  logic signed [PROD_W-1:0]   w_prod [NCH];
  logic signed [ACC_W-1:0]    w_sum;
  logic signed [ACC_W-1:0]    w_src;
  logic signed [ACC_W-1:0]    w_shift;
  logic [NCH*OUT_W-1:0]       w_res;
  logic [NCH-1:0]             w_sat;

  assign w_busy    = (r_tap_cnt != '0) || (r_state != ACCUM);
  assign w_last    = (r_tap_cnt == CNT_W'(TAPS - 1));
  assign w_addr_ok = int'(coef_addr) < TAPS;
  assign w_coef    = r_coef[r_tap_cnt];

  // Products use the coefficient of the current tap; the scale path reads the
  // finished accumulators, so both can share one combinational block.
  always_comb begin
    w_sum   = '0;
    w_src   = '0;
    w_shift = '0;
    w_res   = '0;
    w_sat   = '0;
    for (int c = 0; c < NCH; c++) begin
      w_prod[c] = $signed(tap_data[c*DATA_W +: DATA_W]) * w_coef;
      w_sum     = w_sum + r_acc[c];
    end
    for (int c = 0; c < NCH; c++) begin
      if (mode) begin
        if (c == 0) w_src = w_sum;
        else        w_src = '0;
      end else begin
        w_src = r_acc[c];
      end
      w_shift = w_src >>> FRAC_W;
      if (w_shift > SAT_MAX) begin
        w_res[c*OUT_W +: OUT_W] = SAT_MAX[OUT_W-1:0];
        w_sat[c]                = 1'b1;
      end else if (w_shift < SAT_MIN) begin
        w_res[c*OUT_W +: OUT_W] = SAT_MIN[OUT_W-1:0];
        w_sat[c]                = 1'b1;
      end else begin
        w_res[c*OUT_W +: OUT_W] = w_shift[OUT_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ACCUM;
      r_tap_cnt   <= '0;
      r_tap_ready <= 1'b1;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_sat   <= '0;
      r_coef_err  <= 1'b0;
      for (int t = 0; t < TAPS; t++) r_coef[t] <= '0;
      for (int c = 0; c < NCH; c++) r_acc[c] <= '0;
    end else begin
      r_coef_err <= 1'b0;
      if (coef_we) begin
        if (!w_busy && w_addr_ok) r_coef[coef_addr] <= coef_wdata;
        else                      r_coef_err        <= 1'b1;
      end

      if (clr) begin
        r_state     <= ACCUM;
        r_tap_cnt   <= '0;
        r_tap_ready <= 1'b1;
        r_out_valid <= 1'b0;
      end else begin
        case (r_state)
          ACCUM: begin
            if (tap_valid) begin
              // First tap loads so a new window needs no clear cycle.
              for (int c = 0; c < NCH; c++) begin
                if (r_tap_cnt == '0) r_acc[c] <= ACC_W'(w_prod[c]);
                else                 r_acc[c] <= r_acc[c] + ACC_W'(w_prod[c]);
              end
              if (w_last) begin
                r_tap_cnt   <= '0;
                r_tap_ready <= 1'b0;
                r_state     <= SCALE;
              end else begin
                r_tap_cnt <= r_tap_cnt + 1'b1;
              end
            end
          end
          SCALE: begin
            r_out_data  <= w_res;
            r_out_sat   <= w_sat;
            r_out_valid <= 1'b1;
            r_state     <= OUT;
          end
          OUT: begin
            if (out_ready) begin
              r_out_valid <= 1'b0;
              r_tap_ready <= 1'b1;
              r_state     <= ACCUM;
            end
          end
          default: begin
            r_tap_ready <= 1'b1;
            r_state     <= ACCUM;
          end
        endcase
      end
    end
  end

  assign tap_ready = r_tap_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_sat   = r_out_sat;
  assign coef_err  = r_coef_err;
  assign busy      = w_busy;

endmodule

// File: tb/tb_xrad_conv_engine.sv
// tb/tb_xrad_conv_engine.sv - directed self-checking bench for xrad_conv_engine
module tb_xrad_conv_engine;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clr;
  logic        mode;
  logic        coef_we;
  logic [3:0]  coef_addr;
  logic [15:0] coef_wdata;
  logic        coef_err;
  logic        tap_valid;
  logic        tap_ready;
  logic [63:0] tap_data;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic [3:0]  out_sat;
  logic        busy;

  int          n_chk  = 0;
  int          n_pass = 0;
  int          n_cyc;
  logic [63:0] win [9];
  int          kern [9];

  xrad_conv_engine dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (clr),
    .mode       (mode),
    .coef_we    (coef_we),
    .coef_addr  (coef_addr),
    .coef_wdata (coef_wdata),
    .coef_err   (coef_err),
    .tap_valid  (tap_valid),
    .tap_ready  (tap_ready),
    .tap_data   (tap_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_sat    (out_sat),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  function automatic logic [63:0] pk(input int a, input int b, input int c, input int d);
    return {d[15:0], c[15:0], b[15:0], a[15:0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_coef(input int a, input int d);
    coef_we    = 1'b1;
    coef_addr  = a[3:0];
    coef_wdata = d[15:0];
    tick();
    coef_we    = 1'b0;
  endtask

  task automatic load_kernel();
    for (int i = 0; i < 9; i++) write_coef(i, kern[i]);
  endtask

  task automatic send_window(input int first, input int n);
    int g;
    n_cyc = 0;
    for (int k = first; k < first + n; k++) begin
      tap_valid = 1'b1;
      tap_data  = win[k];
      g = 0;
      while (!tap_ready && g < 20) begin
        tick();
        g++;
        n_cyc++;
      end
      if (!tap_ready) check_eq("tap_ready_timeout", 64'(tap_ready), 64'd1);
      tick();
      n_cyc++;
    end
    tap_valid = 1'b0;
  endtask

  task automatic wait_out(input string tag);
    int g = 0;
    while (!out_valid && g < 10) begin
      tick();
      g++;
    end
    if (!out_valid) check_eq({tag, "_timeout"}, 64'(out_valid), 64'd1);
  endtask

  task automatic take_out();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; clr = 1'b0; mode = 1'b0; coef_we = 1'b0; coef_addr = '0;
    coef_wdata = '0; tap_valid = 1'b0; tap_data = '0; out_ready = 1'b0;
    repeat (3) tick();
    check_eq("rst_out_valid", 64'(out_valid), 64'd0);
    check_eq("rst_out_data",  out_data,       64'd0);
    check_eq("rst_out_sat",   64'(out_sat),   64'd0);
    check_eq("rst_coef_err",  64'(coef_err),  64'd0);
    check_eq("rst_busy",      64'(busy),      64'd0);
    rst_n = 1'b1;
    tick();
    check_eq("rst_tap_ready", 64'(tap_ready), 64'd1);

    // Sobel row kernel, lanes with different patterns
    kern = '{256, 512, 256, 0, 0, 0, -256, -512, -256};
    load_kernel();
    for (int k = 0; k < 9; k++) win[k] = pk(10, k, -10, (k < 3) ? 100 : 0);
    send_window(0, 9);
    check_eq("lat_scale_valid", 64'(out_valid), 64'd0);
    check_eq("lat_scale_busy",  64'(busy),      64'd1);
    check_eq("lat_scale_ready", 64'(tap_ready), 64'd0);
    tick();
    check_eq("lat_out_valid", 64'(out_valid), 64'd1);
    check_eq("sobel_data", out_data, pk(0, -24, 0, 400));
    check_eq("sobel_sat",  64'(out_sat), 64'd0);
    take_out();
    check_eq("sobel_done", 64'(out_valid), 64'd0);

    // All-256 kernel, per-channel, with a 5-cycle output stall
    kern = '{256, 256, 256, 256, 256, 256, 256, 256, 256};
    load_kernel();
    for (int k = 0; k < 9; k++) win[k] = pk(1, 2, 3, 4);
    send_window(0, 9);
    wait_out("flat");
    check_eq("flat_data", out_data, pk(9, 18, 27, 36));
    for (int s = 0; s < 5; s++) begin
      tick();
      check_eq("stall_data",  out_data,       pk(9, 18, 27, 36));
      check_eq("stall_ready", 64'(tap_ready), 64'd0);
    end
    take_out();
    check_eq("b2b_ready", 64'(tap_ready), 64'd1);
    check_eq("b2b_valid", 64'(out_valid), 64'd0);

    // Back-to-back window; mode switched to sum only during SCALE
    send_window(0, 9);
    check_eq("b2b_cycles", 64'(n_cyc), 64'd9);
    mode = 1'b1;
    wait_out("sum");
    check_eq("sum_data", out_data, pk(90, 0, 0, 0));
    mode = 1'b0;
    tick();
    check_eq("sum_hold", out_data, pk(90, 0, 0, 0));
    take_out();

    // Saturation both directions
    kern = '{32767, 32767, 32767, 32767, 32767, 32767, 32767, 32767, 32767};
    load_kernel();
    for (int k = 0; k < 9; k++) win[k] = pk(32767, 32767, 32767, 32767);
    send_window(0, 9);
    wait_out("satp");
    check_eq("satp_data", out_data, pk(32767, 32767, 32767, 32767));
    check_eq("satp_sat",  64'(out_sat), 64'hf);
    take_out();
    for (int k = 0; k < 9; k++) win[k] = pk(-32767, -32767, -32767, -32767);
    send_window(0, 9);
    wait_out("satn");
    check_eq("satn_data", out_data, pk(-32768, -32768, -32768, -32768));
    check_eq("satn_sat",  64'(out_sat), 64'hf);
    take_out();

    // Coefficient write while busy is rejected and leaves the kernel intact
    for (int k = 0; k < 9; k++) win[k] = pk(1, 0, 0, 0);
    send_window(0, 2);
    write_coef(0, 0);
    check_eq("err_busy_pulse", 64'(coef_err), 64'd1);
    tick();
    check_eq("err_busy_clear", 64'(coef_err), 64'd0);
    send_window(2, 7);
    wait_out("err");
    check_eq("err_kept_coef", out_data, pk(1151, 0, 0, 0));
    check_eq("err_kept_sat",  64'(out_sat), 64'd0);
    take_out();
    write_coef(9, 5);
    check_eq("err_addr_pulse", 64'(coef_err), 64'd1);
    write_coef(0, 32767);
    check_eq("err_none", 64'(coef_err), 64'd0);

    // clr after 4 taps, overriding a simultaneous transfer
    kern = '{256, 256, 256, 256, 256, 256, 256, 256, 256};
    load_kernel();
    for (int k = 0; k < 9; k++) win[k] = pk(1000, 1000, 1000, 1000);
    send_window(0, 4);
    check_eq("clr_pre_busy", 64'(busy), 64'd1);
    clr       = 1'b1;
    tap_valid = 1'b1;
    tap_data  = pk(5000, 5000, 5000, 5000);
    tick();
    clr       = 1'b0;
    tap_valid = 1'b0;
    check_eq("clr_busy", 64'(busy), 64'd0);
    for (int k = 0; k < 9; k++) win[k] = pk(1, 2, 3, 4);
    send_window(0, 9);
    wait_out("clr");
    check_eq("clr_fresh", out_data, pk(9, 18, 27, 36));

    // Reset while a result is pending
    rst_n = 1'b0;
    #1;
    check_eq("rst_mid_valid", 64'(out_valid), 64'd0);
    check_eq("rst_mid_data",  out_data,       64'd0);
    check_eq("rst_mid_busy",  64'(busy),      64'd0);
    tick();
    rst_n = 1'b1;
    tick();
    check_eq("rst_post_valid", 64'(out_valid), 64'd0);
    check_eq("rst_post_ready", 64'(tap_ready), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
